// File: rtl/mem_read_seq.sv
`timescale 1ns/1ps
// mem_read_seq: single-outstanding read sequencer for the synchronous word
// memory. Accepts one address, pulses a one-cycle read strobe, waits RD_LAT
// cycles, captures the returned word and holds it until the consumer takes it.
module mem_read_seq #(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_LAT = 2,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic [CW-1:0] rd_count
);

  // Wide enough to hold RD_LAT itself; counts down to 1 at the capture edge.
  localparam int CNTW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] wait_cnt;
  logic            accept;
  logic            capture;
  logic            handoff;

  assign accept  = (state == S_IDLE) && req_valid;
  assign capture = (state == S_WAIT) && (wait_cnt == CNTW'(1));
  assign handoff = (state == S_HOLD) && rsp_ready;

  // State register; reset aborts any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: strictly one request in flight, no queuing.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept)  state_nxt = S_STROBE;
      S_STROBE:              state_nxt = S_WAIT;
      S_WAIT:   if (capture) state_nxt = S_HOLD;
      S_HOLD:   if (handoff) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_STROBE: mem_rd    = 1'b1;
      S_WAIT:   ;
      S_HOLD:   rsp_valid = 1'b1;
      default: begin
        req_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  // Address latch: changes only when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
    end else if (accept) begin
      mem_addr <= req_addr;
    end
  end

  // Latency counter: loaded during the strobe cycle, decremented while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == S_STROBE) begin
      wait_cnt <= CNTW'(RD_LAT);
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - CNTW'(1);
    end
  end

  // Response word: sampled only at the capture edge, frozen through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
    end else if (capture) begin
      rsp_data <= mem_rdata;
    end
  end

  // Completed-read counter, advances on each handoff and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
    end else if (handoff) begin
      rd_count <= rd_count + CW'(1);
    end
  end

endmodule
